// File: rtl/jtag_host_wb_if.sv
// Wishbone slave bundle for the JTAG host.
// Signal names follow the management SoC user-area port.
interface jtag_host_wb_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/jtag_host_wb.sv
// Wishbone-controlled JTAG initiator driving a TAP.
// Optional completion irq: define JTAG_HOST_IRQ_EN.
module jtag_host_wb #(
  parameter logic [31:0] ADDR_BASE = 32'h3000_0000,
  parameter int          DIV_WIDTH = 8,
  parameter int          DIV_RESET = 4
) (
  input  logic           wb_clk_i,
  input  logic           wb_rst_i,
  jtag_host_wb_if.slave  wb,
  output logic           jtag_tck,
  output logic           jtag_tms,
  output logic           jtag_tdi,
  input  logic           jtag_tdo,
  output logic           irq
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
    S_HIGH
  } state_t;

  localparam logic [5:0] A_STAT = 6'd0;
  localparam logic [5:0] A_TMS  = 6'd1;
  localparam logic [5:0] A_TDI  = 6'd2;
  localparam logic [5:0] A_TDO  = 6'd3;
  localparam logic [5:0] A_LEN  = 6'd4;
  localparam logic [5:0] A_DIV  = 6'd5;

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = 1;
  localparam logic [DIV_WIDTH-1:0] DIV_RST =
    DIV_WIDTH'(DIV_RESET);

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_lat;
  logic [5:0]           len_lat;
  logic [4:0]           bit_cnt;
  logic [31:0]          tms_sh, tdi_sh;

  logic [31:0]          tms_r, tdi_r, tdo_r;
  logic [5:0]           len_r;
  logic [DIV_WIDTH-1:0] div_r;
  logic                 ovr, done, ie;
  logic                 ack;
  logic [31:0]          dat_o;

  logic        hit, req, acc, wr;
  logic [5:0]  off;
  logic        busy;
  logic [31:0] rd, mask, wval;
  logic        wr_stat, wr_tms, wr_tdi;
  logic        wr_len, wr_div;
  logic        blocked, start;
  logic [5:0]  len_new, len_clamp;
  logic        sample, shift, finish;
  logic        adr_unused;

  assign adr_unused = ^wb.wbs_adr_i[1:0];

  assign hit = wb.wbs_adr_i[31:8] == ADDR_BASE[31:8];
  assign req = wb.wbs_stb_i & wb.wbs_cyc_i & hit;
  assign acc = req & ~ack;
  assign wr  = acc & wb.wbs_we_i;
  assign off = wb.wbs_adr_i[7:2];

  assign busy = state != S_IDLE;

  assign wb.wbs_ack_o = ack;
  assign wb.wbs_dat_o = dat_o;

  // Register read mux, also the base for byte-merged writes
  always_comb begin
    rd = '0;
    unique case (1'b1)
      off == A_STAT: begin
        rd[0] = busy;
        rd[1] = ovr;
        rd[2] = done;
        rd[8] = ie;
      end
      off == A_TMS: rd = tms_r;
      off == A_TDI: rd = tdi_r;
      off == A_TDO: rd = tdo_r;
      off == A_LEN: rd[5:0] = len_r;
      off == A_DIV: rd[DIV_WIDTH-1:0] = div_r;
      default: rd = '0;
    endcase
  end

  // Byte-select merge and write/start decode
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{wb.wbs_sel_i[i]}};
    end
    wval = (wb.wbs_dat_i & mask) | (rd & ~mask);
    wr_stat = wr & (off == A_STAT);
    wr_tms  = wr & (off == A_TMS);
    wr_tdi  = wr & (off == A_TDI);
    wr_len  = wr & (off == A_LEN);
    wr_div  = wr & (off == A_DIV);
    blocked = busy & (wr_tms | wr_tdi | wr_len | wr_div);
    len_new = wval[5:0];
    len_clamp = (len_new > 6'd32) ? 6'd32 : len_new;
    start = wr_len & ~busy & (len_new != 6'd0);
  end

  // Scan FSM next state and phase events
  always_comb begin
    state_n = state;
    cnt_n   = cnt + DIV_ONE;
    sample  = 1'b0;
    shift   = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (start) state_n = S_LOW;
      end
      S_LOW: begin
        if (cnt == div_lat) begin
          cnt_n   = '0;
          state_n = S_HIGH;
          sample  = 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt == div_lat) begin
          cnt_n = '0;
          if ({1'b0, bit_cnt} == len_lat - 6'd1) begin
            state_n = S_IDLE;
            finish  = 1'b1;
          end else begin
            state_n = S_LOW;
            shift   = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // FSM state, phase counter and registered tck
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= S_IDLE;
      cnt      <= '0;
      jtag_tck <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      jtag_tck <= state_n == S_HIGH;
    end
  end

  // Bus side: ack, read data, host-visible registers
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack   <= 1'b0;
      dat_o <= '0;
      tms_r <= '0;
      tdi_r <= '0;
      len_r <= '0;
      div_r <= DIV_RST;
      ovr   <= 1'b0;
      done  <= 1'b0;
`ifdef JTAG_HOST_IRQ_EN
      ie    <= 1'b0;
`endif
    end else begin
      ack   <= acc;
      dat_o <= (acc & ~wb.wbs_we_i) ? rd : '0;
      if (wr_tms & ~busy) tms_r <= wval;
      if (wr_tdi & ~busy) tdi_r <= wval;
      if (wr_len & ~busy) len_r <= wval[5:0];
      if (wr_div & ~busy) div_r <= wval[DIV_WIDTH-1:0];
      if (wr_stat) begin
        if (wb.wbs_sel_i[0] & wb.wbs_dat_i[1]) ovr <= 1'b0;
        if (wb.wbs_sel_i[0] & wb.wbs_dat_i[2]) done <= 1'b0;
`ifdef JTAG_HOST_IRQ_EN
        ie <= wval[8];
`endif
      end
      if (blocked) ovr <= 1'b1;
      if (start) done <= 1'b0;
      if (finish) done <= 1'b1;
    end
  end

`ifndef JTAG_HOST_IRQ_EN
  assign ie = 1'b0;
`endif

  // Scan datapath: shift copies, pins and tdo capture
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      tms_sh   <= '0;
      tdi_sh   <= '0;
      tdo_r    <= '0;
      bit_cnt  <= '0;
      div_lat  <= '0;
      len_lat  <= '0;
      jtag_tms <= 1'b1;
      jtag_tdi <= 1'b0;
    end else begin
      if (start) begin
        tms_sh   <= tms_r;
        tdi_sh   <= tdi_r;
        tdo_r    <= '0;
        bit_cnt  <= '0;
        div_lat  <= div_r;
        len_lat  <= len_clamp;
        jtag_tms <= tms_r[0];
        jtag_tdi <= tdi_r[0];
      end
      if (sample) tdo_r[bit_cnt] <= jtag_tdo;
      if (shift) begin
        tms_sh   <= tms_sh >> 1;
        tdi_sh   <= tdi_sh >> 1;
        jtag_tms <= tms_sh[1];
        jtag_tdi <= tdi_sh[1];
        bit_cnt  <= bit_cnt + 5'd1;
      end
    end
  end

`ifdef JTAG_HOST_IRQ_EN
  // Level interrupt, registered from done & ie
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) irq <= 1'b0;
    else          irq <= done & ie;
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_host_wb.sv
// Self-checking bench for jtag_host_wb.
// Register table, scans, overrun, irq, reset mid-scan.
module tb_jtag_host_wb;

`ifdef JTAG_HOST_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [5:0] O_STAT = 6'd0;
  localparam logic [5:0] O_TMS  = 6'd1;
  localparam logic [5:0] O_TDI  = 6'd2;
  localparam logic [5:0] O_TDO  = 6'd3;
  localparam logic [5:0] O_LEN  = 6'd4;
  localparam logic [5:0] O_DIV  = 6'd5;
  localparam logic [5:0] O_UNM  = 6'd6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck, tms, tdi, tdo, irq;
  logic loop = 1'b0;

  jtag_host_wb_if bus ();

  jtag_host_wb dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb       (bus),
    .jtag_tck (tck),
    .jtag_tms (tms),
    .jtag_tdi (tdi),
    .jtag_tdo (tdo),
    .irq      (irq)
  );

  assign tdo = loop ? tdi : 1'b0;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          pulses = 0;
  int          last_fall = 0;
  logic        tck_prev = 1'b0;
  logic        tms_and = 1'b1;
  logic [31:0] tdi_cap = '0;

  always @(negedge clk) begin
    if (tck && !tck_prev) begin
      tdi_cap[pulses[4:0]] = tdi;
      tms_and = tms_and & tms;
      pulses = pulses + 1;
    end
    if (!tck && tck_prev) last_fall = cyc;
    tck_prev = tck;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sbq[$];

  task automatic wb_cycle(input logic we,
                          input logic [5:0] off,
                          input logic [31:0] d,
                          input logic [3:0] sel,
                          output logic [31:0] rdat);
    int lat;
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_adr_i = BASE | {24'd0, off, 2'b00};
    bus.wbs_dat_i = d;
    bus.wbs_sel_i = sel;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.wbs_ack_o && lat < 8);
    rdat = bus.wbs_dat_o;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    chk("ack_lat", 32'(lat), 32'd1);
  endtask

  task automatic wb_wr(input logic [5:0] off,
                       input logic [31:0] d,
                       input logic [3:0] sel);
    logic [31:0] dummy;
    wb_cycle(1'b1, off, d, sel, dummy);
  endtask

  task automatic rd_chk(input logic [5:0] off,
                        input logic [31:0] exp,
                        input string name);
    logic [31:0] r;
    sb_t e;
    sbq.push_back('{exp: exp, name: name});
    wb_cycle(1'b0, off, 32'd0, 4'hF, r);
    e = sbq.pop_front();
    chk(e.name, r, e.exp);
  endtask

  task automatic clr_mon();
    pulses = 0;
    tms_and = 1'b1;
    tdi_cap = '0;
  endtask

  task automatic wait_scan(input int np, input int budget);
    int n = 0;
    while (!(pulses == np && !tck) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scan_timeout", 32'(n < budget), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk("pulse_count", 32'(pulses), 32'(np));
  endtask

  typedef struct {
    logic        wr;
    logic [5:0]  off;
    logic [31:0] data;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int t0;
    int n;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = '0;
    bus.wbs_dat_i = '0;

    tbl[0]  = '{0, O_STAT, 0, 4'hF, 32'h0, "rst_status"};
    tbl[1]  = '{0, O_DIV, 0, 4'hF, 32'h4, "rst_div"};
    tbl[2]  = '{0, O_TMS, 0, 4'hF, 32'h0, "rst_tms"};
    tbl[3]  = '{0, O_TDI, 0, 4'hF, 32'h0, "rst_tdi"};
    tbl[4]  = '{0, O_TDO, 0, 4'hF, 32'h0, "rst_tdo"};
    tbl[5]  = '{0, O_LEN, 0, 4'hF, 32'h0, "rst_len"};
    tbl[6]  = '{1, O_DIV, 32'h07, 4'b0001, 32'h07,
                "div_b0"};
    tbl[7]  = '{1, O_DIV, 32'h1234_56FF, 4'b0001,
                32'hFF, "div_trunc"};
    tbl[8]  = '{1, O_DIV, 32'h0000_AB00, 4'b0010,
                32'hFF, "div_b1"};
    tbl[9]  = '{1, O_TMS, 32'hDEAD_BEEF, 4'hF,
                32'hDEAD_BEEF, "tms_full"};
    tbl[10] = '{1, O_TMS, 32'h1122_3344, 4'b0100,
                32'hDE22_BEEF, "tms_b2"};
    tbl[11] = '{1, O_UNM, 32'hFFFF_FFFF, 4'hF, 32'h0,
                "unmapped"};
    tbl[12] = '{1, O_STAT, 32'h106, 4'b0010,
                IRQ_ON ? 32'h100 : 32'h0, "ie_set"};
    tbl[13] = '{1, O_STAT, 32'h0, 4'b0010, 32'h0,
                "ie_clr"};
    tbl[14] = '{1, O_LEN, 32'h0, 4'hF, 32'h0, "len0"};
    tbl[15] = '{0, O_STAT, 0, 4'hF, 32'h0, "len0_idle"};

    // reset state on the pins
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tck", 32'(tck), 32'd0);
    chk("rst_tms", 32'(tms), 32'd1);
    chk("rst_tdi", 32'(tdi), 32'd0);
    chk("rst_ack", 32'(bus.wbs_ack_o), 32'd0);
    chk("rst_dato", bus.wbs_dat_o, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].wr)
        wb_wr(tbl[i].off, tbl[i].data, tbl[i].sel);
      rd_chk(tbl[i].off, tbl[i].exp, tbl[i].name);
    end

    // ack is a single-cycle pulse
    wb_wr(O_DIV, 32'h07, 4'b0001);
    @(posedge clk); #1;
    chk("ack_pulse", 32'(bus.wbs_ack_o), 32'd0);
    rd_chk(O_DIV, 32'h07, "div_07");

    // five-bit scan, DIV=0, tms all ones
    wb_wr(O_DIV, 32'h0, 4'hF);
    wb_wr(O_TMS, 32'h1F, 4'hF);
    wb_wr(O_TDI, 32'h0, 4'hF);
    clr_mon();
    wb_wr(O_LEN, 32'd5, 4'hF);
    t0 = cyc;
    wait_scan(5, 200);
    chk("s5_time", 32'(last_fall - t0), 32'd10);
    chk("s5_tms", 32'(tms_and), 32'd1);
    rd_chk(O_STAT, 32'h4, "s5_done");

    // 32-bit loopback, DIV=2
    loop = 1'b1;
    wb_wr(O_DIV, 32'd2, 4'hF);
    wb_wr(O_TDI, 32'hA5C3_0F1E, 4'hF);
    clr_mon();
    wb_wr(O_LEN, 32'd32, 4'hF);
    t0 = cyc;
    wait_scan(32, 400);
    chk("lb_time", 32'(last_fall - t0), 32'd192);
    chk("lb_tdi", tdi_cap, 32'hA5C3_0F1E);
    rd_chk(O_TDO, 32'hA5C3_0F1E, "lb_tdo");
    loop = 1'b0;

    // clamp LEN=40 and overrun on a busy write
    wb_wr(O_DIV, 32'd1, 4'hF);
    wb_wr(O_TMS, 32'h0, 4'hF);
    wb_wr(O_TDI, 32'h1234_5678, 4'hF);
    clr_mon();
    wb_wr(O_LEN, 32'd40, 4'hF);
    t0 = cyc;
    repeat (6) @(posedge clk);
    wb_wr(O_TDI, 32'hFFFF_FFFF, 4'hF);
    wait_scan(32, 400);
    chk("cl_time", 32'(last_fall - t0), 32'd128);
    chk("cl_tdi", tdi_cap, 32'h1234_5678);
    rd_chk(O_STAT, 32'h6, "ovr_set");
    rd_chk(O_TDI, 32'h1234_5678, "ovr_discard");
    wb_wr(O_STAT, 32'h2, 4'b0001);
    rd_chk(O_STAT, 32'h4, "ovr_w1c");
    wb_wr(O_STAT, 32'h4, 4'b0001);
    rd_chk(O_STAT, 32'h0, "done_w1c");

    // irq, and W1C colliding with completion
    wb_wr(O_DIV, 32'd0, 4'hF);
    wb_wr(O_STAT, 32'h100, 4'b0010);
    chk("irq_pre", 32'(irq), 32'd0);
    clr_mon();
    wb_wr(O_LEN, 32'd1, 4'hF);
    wb_wr(O_STAT, 32'h4, 4'b0001);
    rd_chk(O_STAT, IRQ_ON ? 32'h104 : 32'h4,
           "done_set_wins");
    chk("irq_rise", 32'(irq), 32'(IRQ_ON));
    wb_wr(O_STAT, 32'h4, 4'b0001);
    @(posedge clk); #1;
    chk("irq_fall", 32'(irq), 32'd0);

    // reset asserted during bit 3
    loop = 1'b1;
    wb_wr(O_DIV, 32'd1, 4'hF);
    wb_wr(O_TMS, 32'h0, 4'hF);
    wb_wr(O_TDI, 32'hFFFF_FFFF, 4'hF);
    clr_mon();
    wb_wr(O_LEN, 32'd8, 4'hF);
    n = 0;
    while (pulses < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reach", 32'(pulses >= 3), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_tck", 32'(tck), 32'd0);
    chk("mid_tms", 32'(tms), 32'd1);
    chk("mid_irq", 32'(irq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    loop = 1'b0;
    rd_chk(O_STAT, 32'h0, "mid_status");
    rd_chk(O_TDO, 32'h0, "mid_tdo");
    rd_chk(O_DIV, 32'h4, "mid_div");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
